// File: rtl/audio_dac_pkg.sv
// Shared types and defaults for the delta-sigma audio DAC front end.
// Sample width and rate defaults are shared with the DAC top level.
package audio_dac_pkg;

    localparam int unsigned AUDIO_W                = 16;
    localparam int unsigned AUDIO_CLK_DIV_DEFAULT  = 4;
    localparam int unsigned AUDIO_OSR_LOG2_DEFAULT = 8;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    // Source of the next segment target at a segment boundary
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_NXT    = 2'd1,
        SEL_BYPASS = 2'd2
    } seg_sel_e;

endpackage

// File: rtl/clk_en_gen.sv
// Divides clk by CLK_DIV into a registered one-cycle clock-enable strobe.
// The strobe first appears after the CLK_DIV-th clk edge following reset.
module clk_en_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_en
);

    localparam int unsigned    CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;

    always_comb begin
        cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        clk_en_d = (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_en = clk_en_q;

endmodule

// File: rtl/audio_interp_feeder.sv
// Feeds the delta-sigma modulator: one-sample holding register on a valid/ready
// input, and a linear ramp over 2**OSR_LOG2 modulator ticks between samples.
module audio_interp_feeder
    import audio_dac_pkg::*;
#(
    parameter int unsigned W        = AUDIO_W,
    parameter int unsigned CLK_DIV  = AUDIO_CLK_DIV_DEFAULT,
    parameter int unsigned OSR_LOG2 = AUDIO_OSR_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic signed [W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic                mod_clk_en,
    output logic signed [W-1:0] pcm_out,
    output logic                underrun,
    input  logic                underrun_clr
);

    localparam int unsigned      ACC_W  = W + OSR_LOG2;
    localparam int unsigned      DLT_W  = W + 1;
    localparam int unsigned      PH_W   = OSR_LOG2;
    localparam logic [PH_W-1:0]  PH_MAX = '1;

    logic signed [W-1:0]     cur_q,   cur_d;
    logic signed [W-1:0]     nxt_q,   nxt_d;
    logic                    nxt_vld_q, nxt_vld_d;
    logic signed [ACC_W-1:0] acc_q,   acc_d;
    logic signed [DLT_W-1:0] delta_q, delta_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    underrun_q, underrun_d;

    logic     hs_c;
    logic     tick_c;
    logic     seg_end_c;
    logic     underrun_set_c;
    seg_sel_e sel_c;

    clk_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (mod_clk_en)
    );

    // rst_n gates ready so no handshake can land while reset is asserted
    assign s_tready  = enable & rst_n & ~nxt_vld_q;
    assign hs_c      = s_tvalid & s_tready;
    assign tick_c    = mod_clk_en & enable;
    assign seg_end_c = tick_c & (phase_q == PH_MAX);

    always_comb begin
        sel_c = SEL_HOLD;
        if (nxt_vld_q) begin
            sel_c = SEL_NXT;
        end else if (hs_c) begin
            sel_c = SEL_BYPASS;
        end
    end

    always_comb begin
        cur_d          = cur_q;
        nxt_d          = nxt_q;
        nxt_vld_d      = nxt_vld_q;
        acc_d          = acc_q;
        delta_d        = delta_q;
        phase_d        = phase_q;
        underrun_set_c = 1'b0;

        if (!enable) begin
            cur_d     = '0;
            nxt_d     = '0;
            nxt_vld_d = 1'b0;
            acc_d     = '0;
            delta_d   = '0;
            phase_d   = '0;
        end else begin
            if (hs_c) begin
                nxt_d     = s_tdata;
                nxt_vld_d = 1'b1;
            end

            if (tick_c) begin
                acc_d   = acc_q + ACC_W'(delta_q);
                phase_d = phase_q + PH_W'(1);
            end

            // acc lands on cur<<OSR_LOG2 here; pick the next target
            if (seg_end_c) begin
                case (sel_c)
                    SEL_NXT: begin
                        delta_d   = DLT_W'(nxt_q) - DLT_W'(cur_q);
                        cur_d     = nxt_q;
                        nxt_vld_d = 1'b0;
                    end
                    SEL_BYPASS: begin
                        delta_d   = DLT_W'(s_tdata) - DLT_W'(cur_q);
                        cur_d     = s_tdata;
                        nxt_d     = nxt_q;
                        nxt_vld_d = 1'b0;
                    end
                    default: begin
                        delta_d        = '0;
                        underrun_set_c = 1'b1;
                    end
                endcase
            end
        end

        if (underrun_set_c) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= '0;
            nxt_q      <= '0;
            nxt_vld_q  <= 1'b0;
            acc_q      <= '0;
            delta_q    <= '0;
            phase_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            nxt_vld_q  <= nxt_vld_d;
            acc_q      <= acc_d;
            delta_q    <= delta_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end

    assign pcm_out  = acc_q[ACC_W-1:OSR_LOG2];
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_interp_feeder.sv
// Directed bench for audio_interp_feeder with CLK_DIV=4, OSR_LOG2=2.
module tb_audio_interp_feeder;
    import audio_dac_pkg::*;

    localparam int unsigned W        = 16;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned OSR_LOG2 = 2;
    localparam int          BOUND    = 48;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    enable = 1'b0;
    logic    s_tvalid = 1'b0;
    logic    underrun_clr = 1'b0;
    sample_t s_tdata = '0;
    logic    s_tready;
    logic    mod_clk_en;
    logic    underrun;
    sample_t pcm_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        sample_t smp;
        sample_t e [4];
        logic    un;
    } vec_t;

    vec_t tbl [7];
    sample_t bp_val [3];
    sample_t bp_pcm [3];

    always #5 clk = ~clk;

    audio_interp_feeder #(
        .W        (W),
        .CLK_DIV  (CLK_DIV),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .mod_clk_en   (mod_clk_en),
        .pcm_out      (pcm_out),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int s, input int e0, input int e1,
                           input int e2, input int e3, input logic un);
        tbl[i].smp  = W'(s);
        tbl[i].e[0] = W'(e0);
        tbl[i].e[1] = W'(e1);
        tbl[i].e[2] = W'(e2);
        tbl[i].e[3] = W'(e3);
        tbl[i].un   = un;
    endtask

    // Returns just after the next clk edge on which mod_clk_en is sampled high
    task automatic wait_tick(input string name);
        int n = 0;
        @(negedge clk);
        while (!mod_clk_en && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({name, "_strobe_seen"}, 32'(mod_clk_en), 1);
        @(posedge clk);
        #1;
    endtask

    // Returns at the first negedge with s_tready high
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!s_tready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_seen"}, 32'(s_tready), 1);
    endtask

    task automatic send(input sample_t v, input string name);
        int n = 0;
        @(negedge clk);
        s_tdata  = v;
        s_tvalid = 1'b1;
        while (!s_tready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept"}, 32'(s_tready), 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        underrun_clr = 1'b1;
        @(posedge clk);
        #1;
        underrun_clr = 1'b0;
    endtask

    initial begin
        set_vec(0,  400,  100,  200,  300,  400, 1'b0);
        set_vec(1,  400,  400,  400,  400,  400, 1'b0);
        set_vec(2, -400,  200,    0, -200, -400, 1'b0);
        set_vec(3,    0, -300, -200, -100,    0, 1'b0);
        set_vec(4,    3,    0,    1,    2,    3, 1'b0);
        set_vec(5,    0,    2,    1,    0,    0, 1'b0);
        set_vec(6,   -3,   -1,   -2,   -3,   -3, 1'b1);
        bp_val[0] = 16'sd10;
        bp_val[1] = 16'sd20;
        bp_val[2] = 16'sd30;
        bp_pcm[0] = 16'sd5;
        bp_pcm[1] = 16'sd5;
        bp_pcm[2] = 16'sd10;

        // Reset state with enable and a pending sample already offered
        enable   = 1'b1;
        s_tdata  = 16'sd400;
        s_tvalid = 1'b1;
        #23;
        check("rst_pcm",      32'(pcm_out),    0);
        check("rst_strobe",   32'(mod_clk_en), 0);
        check("rst_ready",    32'(s_tready),   0);
        check("rst_underrun", 32'(underrun),   0);

        // Strobe cadence; 400 is taken on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("strobe_clk%0d", k), 32'(mod_clk_en), (k % 4 == 0) ? 1 : 0);
            if (k == 1) begin
                check("hold_full_ready", 32'(s_tready), 0);
                s_tvalid = 1'b0;
            end
        end
        wait_ready("first_boundary");
        check("first_boundary_pcm", 32'(pcm_out), 0);

        // Ramp table: next sample is queued at the start of each segment
        for (int i = 0; i < 7; i++) begin
            if (i < 6) send(tbl[i+1].smp, $sformatf("tbl%0d", i + 1));
            for (int t = 0; t < 4; t++) begin
                wait_tick($sformatf("tbl%0d_t%0d", i, t));
                check($sformatf("ramp%0d_t%0d", i, t), 32'(pcm_out), 32'(tbl[i].e[t]));
            end
            check($sformatf("ramp%0d_underrun", i), 32'(underrun), 32'(tbl[i].un));
        end

        // Starved: hold last value, clear, then bypass on the boundary cycle
        wait_tick("hold1");
        check("hold_pcm", 32'(pcm_out), -3);
        pulse_clr();
        check("underrun_clr", 32'(underrun), 0);
        wait_tick("hold2");
        wait_tick("hold3");
        begin
            int n = 0;
            @(negedge clk);
            while (!mod_clk_en && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            check("bypass_strobe_seen", 32'(mod_clk_en), 1);
        end
        s_tdata  = 16'sd5;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check("bypass_underrun", 32'(underrun), 0);
        check("bypass_ready",    32'(s_tready), 1);
        check("bypass_pcm",      32'(pcm_out),  -3);
        begin
            int bexp [4] = '{-1, 1, 3, 5};
            for (int t = 0; t < 4; t++) begin
                wait_tick($sformatf("bypass_t%0d", t));
                check($sformatf("bypass_ramp_t%0d", t), 32'(pcm_out), bexp[t]);
            end
        end
        check("bypass_end_underrun", 32'(underrun), 1);
        pulse_clr();
        check("underrun_clr2", 32'(underrun), 0);

        // Backpressure: valid held high across 10, 20, 30
        s_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            s_tdata = bp_val[k];
            @(negedge clk);
            while (!s_tready && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("bp%0d_ready_rise", k), 32'(s_tready), 1);
            check($sformatf("bp%0d_pcm", k), 32'(pcm_out), 32'(bp_pcm[k]));
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_ready_fall", k), 32'(s_tready), 0);
        end
        s_tvalid = 1'b0;
        wait_ready("bp_last");
        check("bp_last_pcm", 32'(pcm_out), 20);
        wait_tick("bp_t0");
        wait_tick("bp_t1");
        wait_tick("bp_t2");
        check("bp_no_underrun", 32'(underrun), 0);
        wait_tick("bp_t3");
        check("bp_end_pcm", 32'(pcm_out), 30);
        check("bp_end_underrun", 32'(underrun), 1);

        // Enable drop at phase 2 of a 30 -> 50 ramp
        send(16'sd50, "en50");
        wait_ready("en50_boundary");
        check("en50_start_pcm", 32'(pcm_out), 30);
        wait_tick("en_t0");
        wait_tick("en_t1");
        check("en_phase2_pcm", 32'(pcm_out), 40);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("dis_ready", 32'(s_tready), 0);
        @(posedge clk);
        #1;
        check("dis_pcm",      32'(pcm_out),  0);
        check("dis_underrun", 32'(underrun), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        send(16'sd8, "reen8");
        wait_ready("reen_boundary");
        check("reen_start_pcm", 32'(pcm_out), 0);
        wait_tick("reen_t0");
        wait_tick("reen_t1");
        check("reen_pcm", 32'(pcm_out), 4);
        check("reen_underrun", 32'(underrun), 1);

        // Asynchronous reset mid-ramp while a handshake is in flight
        begin
            int n = 0;
            @(negedge clk);
            while (!mod_clk_en && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            check("pre_rst_strobe", 32'(mod_clk_en), 1);
        end
        s_tdata  = 16'sd77;
        s_tvalid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_pcm",      32'(pcm_out),    0);
        check("arst_strobe",   32'(mod_clk_en), 0);
        check("arst_ready",    32'(s_tready),   0);
        check("arst_underrun", 32'(underrun),   0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("post_rst_ready", 32'(s_tready), 1);
        check("post_rst_pcm",   32'(pcm_out),  0);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_interp_feeder.md
Name: audio_interp_feeder

Overview:
Upstream stage of the 1-bit delta-sigma audio DAC. Accepts signed PCM samples over a valid/ready stream at the audio sample rate. Generates the modulator clock-enable strobe by dividing the system clock, and drives the modulator's sample input with a linearly interpolated ramp between consecutive samples. Each sample period spans 2**OSR_LOG2 modulator ticks, which suppresses zero-order-hold images before modulation.

Parameters:
W, 16, sample width; signed, full-scale two's complement.
CLK_DIV, 4, system clocks per modulator tick (e.g. 50 MHz to 12.5 MHz).
OSR_LOG2, 8, log2 of modulator ticks per input sample (256 gives about 48.8 kHz at 12.5 MHz).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous assert, active-low.
enable  in  1  block enable; 0 forces the datapath to idle at zero.
s_tdata  in  W  signed PCM sample.
s_tvalid  in  1  sample valid.
s_tready  out  1  sample accepted when s_tvalid and s_tready are both high on a clk edge.
mod_clk_en  out  1  one-cycle modulator strobe, drives the DAC clk_en.
pcm_out  out  W  signed interpolated sample, drives the DAC in; changes only on a clk edge where mod_clk_en=1.
underrun  out  1  sticky: a segment ended with no sample available.
underrun_clr  in  1  single-cycle pulse that clears underrun.

Behaviour:
- Reset (rst_n=0): div_cnt, phase, cur, nxt, nxt_vld, acc, delta and underrun all go to 0. pcm_out=0, mod_clk_en=0, s_tready=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - mod_clk_en = (div_cnt==CLK_DIV-1), registered.
  - The first pulse is on the CLK_DIV-th clk after reset release.
  - The divider runs regardless of enable.
- Holding register:
  - s_tready = enable & ~nxt_vld.
  - On handshake: nxt <= s_tdata, nxt_vld <= 1.
  - Exactly one sample of buffering.
- Interpolator registers:
  - acc: signed, W+OSR_LOG2 bits.
  - delta: signed, W+1 bits.
  - cur: W bits.
  - phase: OSR_LOG2 bits.
- pcm_out = acc[W+OSR_LOG2-1:OSR_LOG2], arithmetic floor.
- On each mod_clk_en with enable=1:
  - acc <= acc + delta; phase <= phase + 1 (wraps).
  - If phase==2**OSR_LOG2-1 (segment end), acc lands exactly on cur<<OSR_LOG2, and the next sample is chosen as follows:
    - If nxt_vld: delta <= nxt - cur; cur <= nxt; nxt_vld <= 0.
    - Else if a handshake happens in the same cycle (bypass): delta <= s_tdata - cur; cur <= s_tdata; nxt_vld stays 0.
    - Else: delta <= 0 (hold cur), underrun <= 1.
- Arithmetic:
  - delta is computed at W+1 bits, so no overflow.
  - acc always lies between the previous and the current sample scaled by 2**OSR_LOG2, so acc never overflows.
  - There is no cumulative error, because each segment ends exactly on a sample.
- Latency: a sample accepted into an empty holding register while a segment is in progress starts ramping at the next segment boundary. pcm_out reaches that sample's value exactly 2**OSR_LOG2 ticks after the boundary.
- underrun: if set and clear happen in the same cycle, the set wins. underrun_clr with no set pending gives underrun <= 0.
- enable=0: synchronously clear cur, nxt, nxt_vld, acc, delta and phase to 0, so pcm_out=0 (DAC idles at midscale). s_tready=0 and underrun is held. On re-enable, ramping starts from 0 at phase 0.
- Reset asserted mid-ramp: all state is cleared immediately, and an in-flight handshake is dropped.

Decomposition:
- Package audio_dac_pkg holds:
  - AUDIO_W = 16.
  - typedef logic signed [AUDIO_W-1:0] sample_t.
  - AUDIO_CLK_DIV_DEFAULT = 4.
  - AUDIO_OSR_LOG2_DEFAULT = 8.
- The package is shared with the DAC top level.
- Sub-module clk_en_gen(CLK_DIV): counter plus strobe, reusable by other audio blocks.

Test Plan:
1. Strobe: CLK_DIV=4, release reset -> mod_clk_en high on clk 4, 8, 12, and never two consecutive cycles.
2. Ramp up: OSR_LOG2=2, enable=1, send 400 from idle -> pcm_out at successive ticks after the boundary is 100, 200, 300, 400, and underrun stays 0 if 400 is sent again in time.
3. Signed ramp and floor: cur=400, send -400 -> 200, 0, -200, -400. Then cur=0, send 3 -> 0, 1, 2, 3 (acc 3, 6, 9, 12). Then send -3 from 0 -> -1, -2, -3, -3 (floors 0, -0.75, -1.5, -2.25, -3).
4. Backpressure: hold s_tvalid high with a sequence 10, 20, 30 -> s_tready falls after each accept and rises one clk after each segment-end consume. No sample is lost or duplicated, and pcm_out ends on 10, then 20, then 30 at segment ends.
5. Underrun and bypass:
   - Stop sending -> pcm_out holds the last value, and underrun=1 from the first starved boundary.
   - Pulse underrun_clr -> 0.
   - Offer a sample exactly on the segment-end cycle -> it is taken by bypass, with no underrun.
6. Enable and reset mid-ramp: drop enable at phase 2 -> pcm_out=0 on the next clk and s_tready=0. Assert rst_n=0 asynchronously mid-ramp -> all outputs are 0 without waiting for a clk edge.
